// File: rtl/hilo_muldiv.sv
// HI/LO execute unit: single-cycle MULT/MULTU/MTHI/MTLO, 32-step restoring DIV/DIVU,
// and MFHI/MFLO read data for the EX result mux.
//
// state | meaning
// IDLE  | accepting ops; HI/LO-class ops complete in the accepting cycle
// RUN   | one restoring divide step per cycle, 32 steps
// DONE  | sign fix-up and HI/LO write of the finished division
module hilo_muldiv #(
    parameter int                  N_DATA       = 32,
    parameter int                  N_ALU_OP     = 8,
    parameter logic [N_ALU_OP-1:0] EXE_MULT_OP  = 8'h18,
    parameter logic [N_ALU_OP-1:0] EXE_MULTU_OP = 8'h19,
    parameter logic [N_ALU_OP-1:0] EXE_DIV_OP   = 8'h1A,
    parameter logic [N_ALU_OP-1:0] EXE_DIVU_OP  = 8'h1B,
    parameter logic [N_ALU_OP-1:0] EXE_MTHI_OP  = 8'h11,
    parameter logic [N_ALU_OP-1:0] EXE_MTLO_OP  = 8'h13,
    parameter logic [N_ALU_OP-1:0] EXE_MFHI_OP  = 8'h10,
    parameter logic [N_ALU_OP-1:0] EXE_MFLO_OP  = 8'h12
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_valid,
    input  logic [N_ALU_OP-1:0] i_alu_op,
    input  logic [N_DATA-1:0]   i_op_reg_0,
    input  logic [N_DATA-1:0]   i_op_reg_1,
    input  logic                i_flush,
    output logic                o_stall_req,
    output logic                o_busy,
    output logic [N_DATA-1:0]   o_hi,
    output logic [N_DATA-1:0]   o_lo,
    output logic [N_DATA-1:0]   o_rdata
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [N_DATA-1:0]   hi_q, lo_q;
    logic [N_DATA-1:0]   rem_q, quot_q, dvs_q;
    logic                q_neg_q, r_neg_q;
    logic [5:0]          cnt_q;

    logic                is_div, is_sdiv, rt_nz, idle, div_req, accept;
    logic [N_DATA-1:0]   abs_rs, abs_rt, q_fin, r_fin;
    logic [2*N_DATA-1:0] mul_s, mul_u;
    logic [N_DATA:0]     rem_sh, diff;

    assign idle    = (state_q == S_IDLE);
    assign is_sdiv = (i_alu_op == EXE_DIV_OP);
    assign is_div  = is_sdiv || (i_alu_op == EXE_DIVU_OP);
    assign rt_nz   = |i_op_reg_1;
    assign div_req = idle && i_valid && is_div && rt_nz;
    assign accept  = idle && i_valid && !i_flush;

    assign abs_rs = (is_sdiv && i_op_reg_0[N_DATA-1]) ? -i_op_reg_0 : i_op_reg_0;
    assign abs_rt = (is_sdiv && i_op_reg_1[N_DATA-1]) ? -i_op_reg_1 : i_op_reg_1;

    assign mul_s = $signed({{N_DATA{i_op_reg_0[N_DATA-1]}}, i_op_reg_0})
                 * $signed({{N_DATA{i_op_reg_1[N_DATA-1]}}, i_op_reg_1});
    assign mul_u = {{N_DATA{1'b0}}, i_op_reg_0} * {{N_DATA{1'b0}}, i_op_reg_1};

    // rem stays below the divisor, so the shifted partial remainder is < 2*divisor
    // and diff[N_DATA] is a clean borrow flag for the trial subtraction.
    assign rem_sh = {rem_q, quot_q[N_DATA-1]};
    assign diff   = rem_sh - {1'b0, dvs_q};

    assign q_fin = q_neg_q ? -quot_q : quot_q;
    assign r_fin = r_neg_q ? -rem_q  : rem_q;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept && div_req) state_d = S_RUN;
            S_RUN: begin
                if (i_flush)              state_d = S_IDLE;
                else if (cnt_q == 6'd31)  state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            hi_q    <= '0;
            lo_q    <= '0;
            rem_q   <= '0;
            quot_q  <= '0;
            dvs_q   <= '0;
            q_neg_q <= 1'b0;
            r_neg_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && accept) begin
                if (i_alu_op == EXE_MULT_OP) begin
                    {hi_q, lo_q} <= mul_s;
                end else if (i_alu_op == EXE_MULTU_OP) begin
                    {hi_q, lo_q} <= mul_u;
                end else if (i_alu_op == EXE_MTHI_OP) begin
                    hi_q <= i_op_reg_0;
                end else if (i_alu_op == EXE_MTLO_OP) begin
                    lo_q <= i_op_reg_0;
                end else if (div_req) begin
                    rem_q   <= '0;
                    quot_q  <= abs_rs;
                    dvs_q   <= abs_rt;
                    q_neg_q <= is_sdiv && (i_op_reg_0[N_DATA-1] ^ i_op_reg_1[N_DATA-1]);
                    r_neg_q <= is_sdiv && i_op_reg_0[N_DATA-1];
                    cnt_q   <= '0;
                end
            end else if (state_q == S_RUN) begin
                rem_q  <= diff[N_DATA] ? rem_sh[N_DATA-1:0] : diff[N_DATA-1:0];
                quot_q <= {quot_q[N_DATA-2:0], ~diff[N_DATA]};
                cnt_q  <= cnt_q + 6'd1;
            end else if (state_q == S_DONE && !i_flush) begin
                hi_q <= r_fin;
                lo_q <= q_fin;
            end
        end
    end

    always_comb begin
        o_rdata = '0;
        if (i_rst_n && i_alu_op == EXE_MFHI_OP)      o_rdata = hi_q;
        else if (i_rst_n && i_alu_op == EXE_MFLO_OP) o_rdata = lo_q;
    end

    assign o_stall_req = i_rst_n && !i_flush && (div_req || state_q == S_RUN);
    assign o_busy      = i_rst_n && !idle;
    assign o_hi        = hi_q;
    assign o_lo        = lo_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
// Bench for hilo_muldiv: directed ops, expectations queued at issue and checked by a
// monitor that pops one entry per retiring instruction.
module tb_hilo_muldiv;

    localparam logic [7:0] OP_MULT  = 8'h18;
    localparam logic [7:0] OP_MULTU = 8'h19;
    localparam logic [7:0] OP_DIV   = 8'h1A;
    localparam logic [7:0] OP_DIVU  = 8'h1B;
    localparam logic [7:0] OP_MTHI  = 8'h11;
    localparam logic [7:0] OP_MTLO  = 8'h13;
    localparam logic [7:0] OP_MFHI  = 8'h10;
    localparam logic [7:0] OP_MFLO  = 8'h12;
    localparam logic [7:0] OP_NONE  = 8'h00;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0;
    logic [7:0]  alu_op = OP_NONE;
    logic [31:0] op0 = '0, op1 = '0;
    logic        flush = 1'b0;
    logic        stall_req, busy;
    logic [31:0] hi, lo, rdata;

    always #5 clk = ~clk;

    hilo_muldiv dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_valid     (valid),
        .i_alu_op    (alu_op),
        .i_op_reg_0  (op0),
        .i_op_reg_1  (op1),
        .i_flush     (flush),
        .o_stall_req (stall_req),
        .o_busy      (busy),
        .o_hi        (hi),
        .o_lo        (lo),
        .o_rdata     (rdata)
    );

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    // An instruction retires at the edge where it is valid and not stalled;
    // its HI/LO result is visible one cycle later.
    logic        ret_pending = 1'b0;
    logic [31:0] ret_rdata;
    exp_t        mon_e;
    always @(negedge clk) begin
        if (ret_pending) begin
            ret_pending = 1'b0;
            if (exp_q.size() == 0) begin
                check("retire_without_expectation", 32'd1, 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check({mon_e.name, ".hi"}, hi, mon_e.hi);
                check({mon_e.name, ".lo"}, lo, mon_e.lo);
                check({mon_e.name, ".rdata"}, ret_rdata, mon_e.rdata);
            end
        end
        if (rst_n && valid && !flush && !stall_req) begin
            ret_pending = 1'b1;
            ret_rdata   = rdata;
        end
    end

    // Called at posedge+1; holds the op through any stall, returns at posedge+1.
    task automatic issue(input string name, input logic [7:0] op,
                         input logic [31:0] rs, input logic [31:0] rt,
                         input logic [31:0] e_hi, input logic [31:0] e_lo,
                         input logic [31:0] e_rd, input int e_stall);
        exp_t e;
        int   n;
        e.name = name; e.hi = e_hi; e.lo = e_lo; e.rdata = e_rd;
        exp_q.push_back(e);
        valid = 1'b1; alu_op = op; op0 = rs; op1 = rt;
        n = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (!stall_req) break;
            n++;
        end
        check({name, ".stall_cycles"}, 32'(n), 32'(e_stall));
        @(posedge clk); #1;
        valid = 1'b0; alu_op = OP_NONE;
    endtask

    initial begin
        // reset with a DIV presented: outputs must stay quiet
        valid = 1'b1; alu_op = OP_DIV; op0 = 32'd7; op1 = 32'd1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset.hi", hi, 32'h0);
        check("reset.lo", lo, 32'h0);
        check("reset.busy", 32'(busy), 32'd0);
        check("reset.stall", 32'(stall_req), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1; valid = 1'b0; alu_op = OP_NONE;

        issue("mult_m1x5",  OP_MULT,  32'hFFFFFFFF, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFFB, 32'h0, 0);
        issue("multu_m1x5", OP_MULTU, 32'hFFFFFFFF, 32'd5, 32'h00000004, 32'hFFFFFFFB, 32'h0, 0);
        issue("mthi",       OP_MTHI,  32'h12345678, 32'h0, 32'h12345678, 32'hFFFFFFFB, 32'h0, 0);
        issue("mfhi",       OP_MFHI,  32'h0,        32'h0, 32'h12345678, 32'hFFFFFFFB, 32'h12345678, 0);
        issue("mtlo",       OP_MTLO,  32'hA5A5A5A5, 32'h0, 32'h12345678, 32'hA5A5A5A5, 32'h0, 0);
        issue("mflo",       OP_MFLO,  32'h0,        32'h0, 32'h12345678, 32'hA5A5A5A5, 32'hA5A5A5A5, 0);
        issue("ignored_op", OP_NONE,  32'hDEADBEEF, 32'h3, 32'h12345678, 32'hA5A5A5A5, 32'h0, 0);
        issue("mult_min_x2", OP_MULT, 32'h80000000, 32'd2, 32'hFFFFFFFF, 32'h00000000, 32'h0, 0);
        issue("div_m7_2",   OP_DIV,   32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'h0, 33);
        issue("divu_m7_2",  OP_DIVU,  32'hFFFFFFF9, 32'd2, 32'h00000001, 32'h7FFFFFFC, 32'h0, 33);
        issue("mthi_11",    OP_MTHI,  32'h11,       32'h0, 32'h11,       32'h7FFFFFFC, 32'h0, 0);
        issue("mtlo_22",    OP_MTLO,  32'h22,       32'h0, 32'h11,       32'h22,       32'h0, 0);
        issue("div_by_0",   OP_DIV,   32'd100,      32'd0, 32'h11,       32'h22,       32'h0, 0);
        issue("divu_by_0",  OP_DIVU,  32'hFFFFFFFF, 32'd0, 32'h11,       32'h22,       32'h0, 0);

        // flush during RUN cycle 10
        valid = 1'b1; alu_op = OP_DIV; op0 = 32'd100; op1 = 32'd3;
        repeat (10) @(posedge clk);
        #1 flush = 1'b1;
        @(negedge clk);
        check("flush.stall", 32'(stall_req), 32'd0);
        check("flush.busy_during", 32'(busy), 32'd1);
        @(posedge clk); #1;
        flush = 1'b0; valid = 1'b0; alu_op = OP_NONE;
        @(negedge clk);
        check("flush.busy_after", 32'(busy), 32'd0);
        check("flush.hi", hi, 32'h11);
        check("flush.lo", lo, 32'h22);
        @(posedge clk); #1;

        issue("mult_3x4",   OP_MULT,  32'd3,   32'd4,        32'h0, 32'hC,        32'h0, 0);
        issue("div_100_m7", OP_DIV,   32'd100, 32'hFFFFFFF9, 32'h2, 32'hFFFFFFF2, 32'h0, 33);

        // synchronous reset during RUN cycle 20
        valid = 1'b1; alu_op = OP_DIV; op0 = 32'd1000; op1 = 32'd7;
        repeat (20) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("rst_run.stall_during", 32'(stall_req), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1; valid = 1'b0; alu_op = OP_NONE;
        @(negedge clk);
        check("rst_run.hi", hi, 32'h0);
        check("rst_run.lo", lo, 32'h0);
        check("rst_run.busy", 32'(busy), 32'd0);
        check("rst_run.stall", 32'(stall_req), 32'd0);
        @(posedge clk); #1;

        issue("div_min_m1", OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 32'h0, 33);

        repeat (3) @(posedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/hilo_muldiv.md
# hilo_muldiv

Execute-stage consumer of the decoder's `o_alu_op` / `o_op_reg_0` / `o_op_reg_1` stream for HI/LO-class instructions. It owns the architectural HI and LO registers and executes MULT, MULTU, MTHI and MTLO in a single cycle. DIV and DIVU run as a 32-iteration restoring divider, and the block requests a pipeline stall while the divider is busy. MFHI/MFLO read data is supplied to the EX result mux.

## Interface
Parameters:
- `N_DATA`, default 32 — operand and HI/LO width; only 32 is supported.

Ports:
- `i_clk`  in  1  system clock
- `i_rst_n`  in  1  reset: synchronous, active-low
- `i_valid`  in  1  a real, non-bubble instruction is in EX this cycle
- `i_alu_op`  in  `N_ALU_OP`  operation code: `EXE_MULT_OP`, `EXE_MULTU_OP`, `EXE_DIV_OP`, `EXE_DIVU_OP`, `EXE_MTHI_OP`, `EXE_MTLO_OP`, `EXE_MFHI_OP`, `EXE_MFLO_OP`; all other codes are ignored
- `i_op_reg_0`  in  32  rs value; dividend or multiplicand; source for MTHI/MTLO
- `i_op_reg_1`  in  32  rt value; divisor or multiplier
- `i_flush`  in  1  annul any in-flight division
- `o_stall_req`  out  1  hold IF/ID/EX
- `o_busy`  out  1  divider state is not IDLE
- `o_hi`, `o_lo`  out  32  architectural HI and LO
- `o_rdata`  out  32  HI when the op is MFHI, LO when the op is MFLO, otherwise 0

## Operation
- Reset (`i_rst_n`=0 at a clock edge): HI=0, LO=0, state=IDLE, divider registers=0. Combinationally, `o_stall_req`=0, `o_busy`=0 and `o_rdata`=0.
- An op is accepted only when `i_valid`=1 and state=IDLE.
- MULT: {HI,LO} <= signed 32x32 product (64-bit), written at the end of the accepting cycle.
- MULTU: same as MULT, with an unsigned product.
- MTHI: HI <= rs. MTLO: LO <= rs. Both written at the end of the accepting cycle. MTHI leaves LO unchanged; MTLO leaves HI unchanged.
- MFHI/MFLO: `o_rdata` is the current register value, combinational. No state change.
- DIV/DIVU with rt==0: no stall, no state change, HI/LO unchanged. The instruction retires as a no-op.
- DIV/DIVU with rt!=0 uses the state machine IDLE -> RUN -> DONE -> IDLE:
  - IDLE, on accept: latch |rs|, |rt| (DIVU uses the raw values), the quotient sign (rs[31]^rt[31]) and the remainder sign (rs[31]). Clear the 6-bit counter. Go to RUN.
  - RUN: one restoring step per cycle. Shift the {rem, quot} 64-bit register left by 1. Trial-subtract the divisor from rem[32:0]; if it is non-negative, keep the difference and set quot[0]=1. Increment the counter. After 32 steps go to DONE.
  - DONE: apply signs for DIV (quotient negated when its sign bit is 1; remainder negated when its sign bit is 1). HI <= remainder, LO <= quotient at the end of this cycle. Go to IDLE.
- `o_stall_req` = !`i_flush` && ((IDLE && `i_valid` && div op && rt!=0) || RUN). It is low in DONE, so the held DIV retires as HI/LO are written.
- `o_busy` = (state != IDLE).
- `i_flush` in RUN or DONE: next state is IDLE, with no HI/LO write. `i_flush` in IDLE blocks acceptance of any op that cycle.
- Ops presented while state != IDLE are ignored. This is legal only via the stall hold of the same DIV.
- Arithmetic: DIV of 0x80000000 by 0xFFFFFFFF gives LO=0x80000000, HI=0 (wraps; no trap).

## Timing
- MULT, MULTU, MTHI, MTLO: 1 cycle. The new HI/LO value is visible on `o_hi`/`o_lo`/`o_rdata` in the next cycle.
- DIV/DIVU with a non-zero divisor, accepted in cycle 0:
  - `o_stall_req` is high in cycles 0..32 (33 cycles).
  - RUN occupies cycles 1..32.
  - DONE is cycle 33; HI/LO are updated at the end of cycle 33 and visible in cycle 34.
- A back-to-back DIV presented in cycle 34 is accepted normally.
- Synchronous reset during RUN: IDLE next cycle, HI/LO cleared.

## Test plan
- MULT rs=0xFFFFFFFF (-1), rt=5 -> HI=0xFFFFFFFF, LO=0xFFFFFFFB one cycle later. MULTU with the same operands -> HI=0x00000004, LO=0xFFFFFFFB.
- MTHI 0x12345678 then MFHI -> `o_rdata`=0x12345678; LO unchanged. MTLO 0xA5A5A5A5 then MFLO -> `o_rdata`=0xA5A5A5A5.
- DIV rs=-7 (0xFFFFFFF9), rt=2 -> stall high for exactly 33 cycles, then LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1). DIVU with the same operands -> LO=0x7FFFFFFC, HI=1.
- DIV rt=0 with HI=0x11, LO=0x22 preloaded -> `o_stall_req` never asserts; HI/LO stay 0x11/0x22.
- DIV accepted, `i_flush` pulsed in RUN cycle 10 -> `o_stall_req`=0 that cycle, `o_busy`=0 the next cycle, HI/LO unchanged. A following MULT 3*4 -> LO=12.
- `i_rst_n`=0 during RUN cycle 20 -> next cycle HI=LO=0, `o_busy`=0, `o_stall_req`=0. DIV 0x80000000 / 0xFFFFFFFF afterwards -> LO=0x80000000, HI=0.
